// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART byte engine: TX/RX state encodings,
// parity-mode constants and the clocks-per-bit helper.
// No ports (package).
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
        TX_PARITY = 3'd3,
        TX_STOP   = 3'd4
    } tx_state_e;

    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_START  = 3'd1,
        RX_DATA   = 3'd2,
        RX_PARITY = 3'd3,
        RX_STOP   = 3'd4
    } rx_state_e;

    // Integer division: any remainder is dropped, so the real baud rate is
    // slightly higher than requested when the ratio is not exact.
    function automatic int calc_clks_per_bit(input int clock_frequency, input int baud_rate);
        return clock_frequency / baud_rate;
    endfunction

endpackage

// File: rtl/uart_rx_path.sv
// -----------------------------------------------------------------------------
// uart_rx_path
// Receive half of the UART engine: 2-flop synchroniser, falling-edge start
// detection with mid-bit false-start rejection, mid-bit sampling of data,
// parity and stop bits, and parity/framing error reporting.
// Ports:
//   clk, rst_n      clock and asynchronous active-low reset
//   rx_serial_in    raw serial line, asynchronous to clk
//   rx_data         last received word (held until next frame)
//   rx_ready        one-cycle pulse when a frame completes
//   rx_error        parity or framing error of the last frame
// -----------------------------------------------------------------------------
module uart_rx_path
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT  = 5208,
    parameter int PARITY        = 1,
    parameter int NUM_DATA_BITS = 8,
    parameter int NUM_STOP_BITS = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     rx_serial_in,
    output logic [NUM_DATA_BITS-1:0] rx_data,
    output logic                     rx_ready,
    output logic                     rx_error
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_W = $clog2(NUM_DATA_BITS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF   = CNT_W'(CLKS_PER_BIT / 2);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DATA_BITS - 1);
    localparam logic             STOP_LAST  = 1'(NUM_STOP_BITS - 1);
    localparam logic             HAS_PARITY = (PARITY != PARITY_NONE);
    localparam logic             ODD_MODE   = (PARITY == PARITY_ODD);

    rx_state_e                state_q, state_d;
    logic                     sync1_q, sync1_d;
    logic                     sync2_q, sync2_d;
    logic                     prev_q, prev_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic                     stop_idx_q, stop_idx_d;
    logic [NUM_DATA_BITS-1:0] shift_q, shift_d;
    logic                     parity_err_q, parity_err_d;
    logic                     stop_err_q, stop_err_d;
    logic [NUM_DATA_BITS-1:0] data_q, data_d;
    logic                     ready_q, ready_d;
    logic                     error_q, error_d;
    logic                     bit_end;

    // Synchronisers reset to the idle-high level so leaving reset never
    // looks like a start-bit edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= RX_IDLE;
            sync1_q      <= 1'b1;
            sync2_q      <= 1'b1;
            prev_q       <= 1'b1;
            cnt_q        <= '0;
            idx_q        <= '0;
            stop_idx_q   <= 1'b0;
            shift_q      <= '0;
            parity_err_q <= 1'b0;
            stop_err_q   <= 1'b0;
            data_q       <= '0;
            ready_q      <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            prev_q       <= prev_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            stop_idx_q   <= stop_idx_d;
            shift_q      <= shift_d;
            parity_err_q <= parity_err_d;
            stop_err_q   <= stop_err_d;
            data_q       <= data_d;
            ready_q      <= ready_d;
            error_q      <= error_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        sync1_d      = rx_serial_in;
        sync2_d      = sync1_q;
        prev_d       = sync2_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        stop_idx_d   = stop_idx_q;
        shift_d      = shift_q;
        parity_err_d = parity_err_q;
        stop_err_d   = stop_err_q;
        data_d       = data_q;
        ready_d      = 1'b0;
        error_d      = error_q;
        bit_end      = (cnt_q == CNT_LAST);

        if (state_q != RX_IDLE) begin
            cnt_d = bit_end ? '0 : cnt_q + CNT_W'(1);
        end

        case (state_q)
            RX_IDLE: begin
                cnt_d        = '0;
                idx_d        = '0;
                stop_idx_d   = 1'b0;
                parity_err_d = 1'b0;
                stop_err_d   = 1'b0;
                if (prev_q && !sync2_q) begin
                    state_d = RX_START;
                end
            end
            // Re-check at mid start bit; restarting the counter here puts
            // every later sample at the middle of its bit.
            RX_START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d   = '0;
                    state_d = sync2_q ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (bit_end) begin
                    shift_d = {sync2_q, shift_q[NUM_DATA_BITS-1:1]};
                    if (idx_q == IDX_LAST) begin
                        idx_d   = '0;
                        state_d = HAS_PARITY ? RX_PARITY : RX_STOP;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            RX_PARITY: begin
                if (bit_end) begin
                    parity_err_d = ((^shift_q) ^ sync2_q) != ODD_MODE;
                    state_d      = RX_STOP;
                end
            end
            // The final stop sample completes the frame and returns to idle
            // at once, so a back-to-back start bit is not missed.
            RX_STOP: begin
                if (bit_end) begin
                    if (stop_idx_q == STOP_LAST) begin
                        data_d  = shift_q;
                        error_d = parity_err_q | stop_err_q | ~sync2_q;
                        ready_d = 1'b1;
                        state_d = RX_IDLE;
                    end else begin
                        stop_err_d = stop_err_q | ~sync2_q;
                        stop_idx_d = 1'b1;
                    end
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    assign rx_data  = data_q;
    assign rx_ready = ready_q;
    assign rx_error = error_q;

endmodule

// File: rtl/uart_tx_rx_module.sv
// -----------------------------------------------------------------------------
// uart_tx_rx_module
// Full-duplex UART byte engine. TX serialises one word per launch (start,
// data LSB first, optional parity, stop bits); RX is delegated to
// uart_rx_path. TX and RX share only the clock and reset.
// Ports:
//   IN_CLOCK, IN_RESET_N        clock, asynchronous active-low reset
//   IN_TX_LAUNCH, IN_TX_DATA    level launch request and word to send
//   OUT_TX_ACTIVE/DONE          frame in progress / end-of-frame pulse
//   OUT_TX_START_BIT_ACTIVE     high during the start bit
//   OUT_TX_STOP_BIT_ACTIVE      high during all stop bits
//   OUT_TX_SERIAL               serial output, idles high
//   IN_RX_SERIAL                serial input
//   OUT_RX_DATA/READY/ERROR     received word, completion pulse, error
// -----------------------------------------------------------------------------
module uart_tx_rx_module
    import uart_pkg::*;
#(
    parameter int UART_BAUD_RATE           = 9600,
    parameter int CLOCK_FREQUENCY          = 50000000,
    parameter int PARITY                   = 1,
    parameter int NUM_OF_DATA_BITS_IN_PACK = 8,
    parameter int NUMBER_STOP_BITS         = 2
) (
    input  logic                                IN_CLOCK,
    input  logic                                IN_RESET_N,
    input  logic                                IN_TX_LAUNCH,
    input  logic [NUM_OF_DATA_BITS_IN_PACK-1:0] IN_TX_DATA,
    output logic                                OUT_TX_ACTIVE,
    output logic                                OUT_TX_DONE,
    output logic                                OUT_TX_START_BIT_ACTIVE,
    output logic                                OUT_TX_STOP_BIT_ACTIVE,
    output logic                                OUT_TX_SERIAL,
    input  logic                                IN_RX_SERIAL,
    output logic [NUM_OF_DATA_BITS_IN_PACK-1:0] OUT_RX_DATA,
    output logic                                OUT_RX_DATA_READY,
    output logic                                OUT_RX_ERROR
);

    localparam int N            = NUM_OF_DATA_BITS_IN_PACK;
    localparam int CLKS_PER_BIT = calc_clks_per_bit(CLOCK_FREQUENCY, UART_BAUD_RATE);
    localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_W        = $clog2(N + 1);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(N - 1);
    localparam logic             STOP_LAST  = 1'(NUMBER_STOP_BITS - 1);
    localparam logic             HAS_PARITY = (PARITY != PARITY_NONE);
    localparam logic             ODD_MODE   = (PARITY == PARITY_ODD);

    tx_state_e        tx_state_q, tx_state_d;
    logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
    logic [IDX_W-1:0] tx_idx_q, tx_idx_d;
    logic             tx_stop_idx_q, tx_stop_idx_d;
    logic [N-1:0]     tx_shift_q, tx_shift_d;
    logic             tx_parity_q, tx_parity_d;
    logic             tx_done_q, tx_done_d;
    logic             tx_bit_end;

    always_ff @(posedge IN_CLOCK or negedge IN_RESET_N) begin
        if (!IN_RESET_N) begin
            tx_state_q    <= TX_IDLE;
            tx_cnt_q      <= '0;
            tx_idx_q      <= '0;
            tx_stop_idx_q <= 1'b0;
            tx_shift_q    <= '0;
            tx_parity_q   <= 1'b0;
            tx_done_q     <= 1'b0;
        end else begin
            tx_state_q    <= tx_state_d;
            tx_cnt_q      <= tx_cnt_d;
            tx_idx_q      <= tx_idx_d;
            tx_stop_idx_q <= tx_stop_idx_d;
            tx_shift_q    <= tx_shift_d;
            tx_parity_q   <= tx_parity_d;
            tx_done_q     <= tx_done_d;
        end
    end

    always_comb begin
        tx_state_d    = tx_state_q;
        tx_cnt_d      = tx_cnt_q;
        tx_idx_d      = tx_idx_q;
        tx_stop_idx_d = tx_stop_idx_q;
        tx_shift_d    = tx_shift_q;
        tx_parity_d   = tx_parity_q;
        tx_done_d     = 1'b0;
        tx_bit_end    = (tx_cnt_q == CNT_LAST);

        if (tx_state_q != TX_IDLE) begin
            tx_cnt_d = tx_bit_end ? '0 : tx_cnt_q + CNT_W'(1);
        end

        case (tx_state_q)
            // The word and its parity are captured together so later changes
            // on IN_TX_DATA cannot disturb the frame in flight.
            TX_IDLE: begin
                tx_cnt_d      = '0;
                tx_idx_d      = '0;
                tx_stop_idx_d = 1'b0;
                if (IN_TX_LAUNCH) begin
                    tx_shift_d  = IN_TX_DATA;
                    tx_parity_d = (^IN_TX_DATA) ^ ODD_MODE;
                    tx_state_d  = TX_START;
                end
            end
            TX_START: begin
                if (tx_bit_end) begin
                    tx_state_d = TX_DATA;
                end
            end
            // Shifting right keeps the current bit at position 0.
            TX_DATA: begin
                if (tx_bit_end) begin
                    tx_shift_d = tx_shift_q >> 1;
                    if (tx_idx_q == IDX_LAST) begin
                        tx_idx_d   = '0;
                        tx_state_d = HAS_PARITY ? TX_PARITY : TX_STOP;
                    end else begin
                        tx_idx_d = tx_idx_q + IDX_W'(1);
                    end
                end
            end
            TX_PARITY: begin
                if (tx_bit_end) begin
                    tx_state_d = TX_STOP;
                end
            end
            TX_STOP: begin
                if (tx_bit_end) begin
                    if (tx_stop_idx_q == STOP_LAST) begin
                        tx_state_d = TX_IDLE;
                        tx_done_d  = 1'b1;
                    end else begin
                        tx_stop_idx_d = 1'b1;
                    end
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    // Outputs decode straight from registered state, so an asynchronous
    // reset forces the line high and ACTIVE low without waiting for a clock.
    always_comb begin
        case (tx_state_q)
            TX_START:  OUT_TX_SERIAL = 1'b0;
            TX_DATA:   OUT_TX_SERIAL = tx_shift_q[0];
            TX_PARITY: OUT_TX_SERIAL = tx_parity_q;
            default:   OUT_TX_SERIAL = 1'b1;
        endcase
    end

    assign OUT_TX_ACTIVE           = (tx_state_q != TX_IDLE);
    assign OUT_TX_START_BIT_ACTIVE = (tx_state_q == TX_START);
    assign OUT_TX_STOP_BIT_ACTIVE  = (tx_state_q == TX_STOP);
    assign OUT_TX_DONE             = tx_done_q;

    uart_rx_path #(
        .CLKS_PER_BIT  (CLKS_PER_BIT),
        .PARITY        (PARITY),
        .NUM_DATA_BITS (N),
        .NUM_STOP_BITS (NUMBER_STOP_BITS)
    ) u_rx_path (
        .clk          (IN_CLOCK),
        .rst_n        (IN_RESET_N),
        .rx_serial_in (IN_RX_SERIAL),
        .rx_data      (OUT_RX_DATA),
        .rx_ready     (OUT_RX_DATA_READY),
        .rx_error     (OUT_RX_ERROR)
    );

endmodule

// File: tb/tb_uart_tx_rx_module.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_rx_module
// Directed bench for uart_tx_rx_module at 10 clocks per bit, even parity,
// 8 data bits, 2 stop bits. TX waveforms are checked cycle by cycle in the
// stimulus thread; received words go through a scoreboard queue that a
// separate monitor drains on every RX ready pulse.
// -----------------------------------------------------------------------------
module tb_uart_tx_rx_module;

    localparam int CLK_FREQ     = 1000000;
    localparam int BAUD         = 100000;
    localparam int CPB          = 10;
    localparam int NB           = 8;
    localparam int NS           = 2;
    localparam int FRAME_CYCLES = (1 + NB + 1 + NS) * CPB;

    typedef struct packed {
        logic [7:0] data;
        logic       err;
    } rx_exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       launch = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_active, tx_done, tx_start_act, tx_stop_act, tx_serial;
    logic       rx_serial;
    logic       rx_drive = 1'b1;
    logic       loopback = 1'b1;
    logic [7:0] rx_data;
    logic       rx_ready, rx_error;

    rx_exp_t exp_q[$];
    int      errors = 0;
    int      checks = 0;
    int      ready_count = 0;

    assign rx_serial = loopback ? tx_serial : rx_drive;

    always #5 clk = ~clk;

    uart_tx_rx_module #(
        .UART_BAUD_RATE           (BAUD),
        .CLOCK_FREQUENCY          (CLK_FREQ),
        .PARITY                   (1),
        .NUM_OF_DATA_BITS_IN_PACK (NB),
        .NUMBER_STOP_BITS         (NS)
    ) dut (
        .IN_CLOCK                (clk),
        .IN_RESET_N              (rst_n),
        .IN_TX_LAUNCH            (launch),
        .IN_TX_DATA              (tx_data),
        .OUT_TX_ACTIVE           (tx_active),
        .OUT_TX_DONE             (tx_done),
        .OUT_TX_START_BIT_ACTIVE (tx_start_act),
        .OUT_TX_STOP_BIT_ACTIVE  (tx_stop_act),
        .OUT_TX_SERIAL           (tx_serial),
        .IN_RX_SERIAL            (rx_serial),
        .OUT_RX_DATA             (rx_data),
        .OUT_RX_DATA_READY       (rx_ready),
        .OUT_RX_ERROR            (rx_error)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Presents a word with launch high just before a rising edge; that edge
    // is cycle 0 of the frame.
    task automatic applyStimulus(input logic [7:0] d);
        @(negedge clk);
        tx_data = d;
        launch  = 1'b1;
        @(posedge clk);
    endtask

    // Watches cycles 1..FRAME_CYCLES+1 after the launch edge against a
    // per-cycle model of the frame. Launch is dropped at cycle 1 unless held;
    // IN_TX_DATA is changed to next_data in the middle of the stop bits.
    task automatic observeTxFrame(input string tag, input logic [7:0] d, input logic hold_launch,
                                  input logic [7:0] next_data);
        logic [11:0] frame;
        int bad_serial, bad_active, bad_start, bad_stop, bad_done, done_cnt;
        logic exp_serial;
        frame = {2'b11, ^d, d, 1'b0};
        bad_serial = 0; bad_active = 0; bad_start = 0; bad_stop = 0; bad_done = 0; done_cnt = 0;
        if (loopback) exp_q.push_back('{data: d, err: 1'b0});
        for (int k = 1; k <= FRAME_CYCLES + 1; k++) begin
            @(negedge clk);
            exp_serial = (k <= FRAME_CYCLES) ? frame[(k - 1) / CPB] : 1'b1;
            if (tx_serial !== exp_serial) bad_serial++;
            if (tx_active !== (k <= FRAME_CYCLES)) bad_active++;
            if (tx_start_act !== (k <= CPB)) bad_start++;
            if (tx_stop_act !== (k > FRAME_CYCLES - NS * CPB && k <= FRAME_CYCLES)) bad_stop++;
            if (tx_done !== (k == FRAME_CYCLES + 1)) bad_done++;
            if (tx_done === 1'b1) done_cnt++;
            if (k == 1 && !hold_launch) launch = 1'b0;
            if (k == FRAME_CYCLES - 15) tx_data = next_data;
        end
        checkOutput({tag, "_serial_bad_cycles"}, bad_serial, 0);
        checkOutput({tag, "_active_bad_cycles"}, bad_active, 0);
        checkOutput({tag, "_start_bit_bad_cycles"}, bad_start, 0);
        checkOutput({tag, "_stop_bit_bad_cycles"}, bad_stop, 0);
        checkOutput({tag, "_done_bad_cycles"}, bad_done, 0);
        checkOutput({tag, "_done_pulses"}, done_cnt, 1);
    endtask

    // Drives one RX frame directly: start, data LSB first, parity, 2 stops.
    task automatic sendRxFrame(input logic [7:0] d, input logic p, input logic s0, input logic s1);
        logic [11:0] bits;
        bits = {s1, s0, p, d, 1'b0};
        for (int b = 0; b < 12; b++) begin
            @(negedge clk);
            rx_drive = bits[b];
            repeat (CPB - 1) @(negedge clk);
        end
        @(negedge clk);
        rx_drive = 1'b1;
    endtask

    // Scoreboard monitor: every ready pulse must match the oldest expectation.
    initial begin
        rx_exp_t e;
        forever begin
            @(negedge clk);
            if (rx_ready === 1'b1) begin
                ready_count++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL rx_unexpected_ready: got data=%0h err=%0b, expected no frame",
                             rx_data, rx_error);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("rx_data", rx_data, e.data);
                    checkOutput("rx_error", rx_error, e.err);
                end
            end
        end
    end

    initial begin
        int rc0;
        int dn;

        // Reset state
        repeat (2) @(negedge clk);
        checkOutput("reset_tx_serial", tx_serial, 1);
        checkOutput("reset_tx_active", tx_active, 0);
        checkOutput("reset_tx_done", tx_done, 0);
        checkOutput("reset_tx_start_bit", tx_start_act, 0);
        checkOutput("reset_tx_stop_bit", tx_stop_act, 0);
        checkOutput("reset_rx_data", rx_data, 0);
        checkOutput("reset_rx_ready", rx_ready, 0);
        checkOutput("reset_rx_error", rx_error, 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Single frame 0xA5 with loopback
        $display("[TB] frame 0xA5 loopback");
        applyStimulus(8'hA5);
        observeTxFrame("a5", 8'hA5, 1'b0, 8'h00);
        repeat (10) @(negedge clk);

        // Launch held across two frames, data changed during stop bits
        $display("[TB] back-to-back 0x01 then 0xFF");
        applyStimulus(8'h01);
        observeTxFrame("b2b_first", 8'h01, 1'b1, 8'hFF);
        observeTxFrame("b2b_second", 8'hFF, 1'b0, 8'h00);
        repeat (10) @(negedge clk);

        // Reset 50 cycles into a frame
        $display("[TB] reset mid-frame");
        rc0 = ready_count;
        applyStimulus(8'h5A);
        for (int i = 1; i <= 50; i++) begin
            @(negedge clk);
            if (i == 1) launch = 1'b0;
        end
        #1 rst_n = 1'b0;
        #1;
        checkOutput("abort_tx_serial", tx_serial, 1);
        checkOutput("abort_tx_active", tx_active, 0);
        checkOutput("abort_tx_start_stop", {tx_start_act, tx_stop_act}, 0);
        dn = 0;
        repeat (5) begin
            @(negedge clk);
            if (tx_done === 1'b1) dn++;
        end
        rst_n = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (tx_done === 1'b1) dn++;
        end
        checkOutput("abort_no_done", dn, 0);
        checkOutput("abort_no_ready", ready_count, rc0);
        applyStimulus(8'hC3);
        observeTxFrame("after_reset_c3", 8'hC3, 1'b0, 8'h00);
        repeat (10) @(negedge clk);

        // Direct RX drive: parity error then good frame
        $display("[TB] RX direct frames");
        @(negedge clk);
        loopback = 1'b0;
        repeat (5) @(negedge clk);
        exp_q.push_back('{data: 8'h3C, err: 1'b1});
        sendRxFrame(8'h3C, 1'b1, 1'b1, 1'b1);
        repeat (15) @(negedge clk);
        exp_q.push_back('{data: 8'h3C, err: 1'b0});
        sendRxFrame(8'h3C, 1'b0, 1'b1, 1'b1);
        repeat (15) @(negedge clk);

        // Glitch then framing error
        rc0 = ready_count;
        rx_drive = 1'b0;
        repeat (3) @(negedge clk);
        rx_drive = 1'b1;
        repeat (30) @(negedge clk);
        checkOutput("glitch_no_ready", ready_count, rc0);
        exp_q.push_back('{data: 8'h96, err: 1'b1});
        sendRxFrame(8'h96, 1'b0, 1'b0, 1'b1);
        repeat (15) @(negedge clk);
        checkOutput("rx_data_hold", rx_data, 8'h96);
        checkOutput("rx_error_hold", rx_error, 1);

        repeat (20) @(negedge clk);
        checkOutput("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
